// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and flag bit positions.
package seq_alu_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_ADDU = 4'd2,
        OP_ADDC = 4'd3,
        OP_SUB  = 4'd4,
        OP_CMP  = 4'd5,
        OP_AND  = 4'd6,
        OP_OR   = 4'd7,
        OP_XOR  = 4'd8,
        OP_NOT  = 4'd9,
        OP_LSH  = 4'd10,
        OP_RSH  = 4'd11,
        OP_ARSH = 4'd12,
        OP_MUL  = 4'd13
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_MUL
    } state_t;

    localparam int unsigned FLAG_Z = 4;
    localparam int unsigned FLAG_C = 3;
    localparam int unsigned FLAG_F = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_L = 0;

    function automatic logic is_shift(input alu_op_t op);
        return op inside {OP_LSH, OP_RSH, OP_ARSH};
    endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative engine: one-bit-per-cycle shifter and unsigned shift-add multiplier.
module seq_alu_iter
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  alu_op_t          i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [CW-1:0]    i_count,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    alu_op_t          r_op;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mc;
    logic [WIDTH-1:0] r_mp;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_step;

    always_comb begin
        w_step = r_acc;
        case (r_op)
            OP_LSH:  w_step = {r_acc[WIDTH-2:0], 1'b0};
            OP_RSH:  w_step = {1'b0, r_acc[WIDTH-1:1]};
            OP_ARSH: w_step = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
            OP_MUL:  w_step = r_mp[0] ? (r_acc + r_mc) : r_acc;
            default: w_step = r_acc;
        endcase
    end

    // The final step is taken combinationally so the top can register it with out_valid.
    assign o_done   = (r_cnt == CW'(1));
    assign o_result = w_step;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op  <= OP_NOP;
            r_acc <= '0;
            r_mc  <= '0;
            r_mp  <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_op  <= i_op;
            r_acc <= (i_op == OP_MUL) ? '0 : i_a;
            r_mc  <= i_a;
            r_mp  <= i_b;
            r_cnt <= i_count;
        end else if (r_cnt != '0) begin
            r_acc <= w_step;
            r_mc  <= {r_mc[WIDTH-2:0], 1'b0};
            r_mp  <= {1'b0, r_mp[WIDTH-1:1]};
            r_cnt <= r_cnt - CW'(1);
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle datapath plus an iterative shift/multiply engine,
// valid/ready input handshake and registered result/flags.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IMM_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [IMM_W-1:0] imm,
    input  logic             use_imm,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags
);

    localparam int unsigned      CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_MAX = CW'(WIDTH);
    localparam logic [WIDTH-1:0] AMT_MAX = WIDTH'(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_result;
    logic [4:0]       r_flags;
    logic             r_out_valid;

    alu_op_t          w_op;
    logic             w_accept;
    logic             w_start_iter;
    logic             w_sc_wr;
    logic             w_iter_done;
    logic             w_cin;
    logic [WIDTH-1:0] w_imm_ext;
    logic [WIDTH-1:0] w_opb;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_sc_res;
    logic [WIDTH-1:0] w_iter_res;
    logic [WIDTH:0]   w_sum;
    logic [4:0]       w_sc_flags;
    logic [4:0]       w_iter_flags;
    logic [CW-1:0]    w_amt;
    logic [CW-1:0]    w_iter_cnt;

    assign w_op      = alu_op_t'(op);
    assign w_imm_ext = (w_op inside {OP_ADD, OP_ADDC, OP_SUB, OP_CMP})
                       ? WIDTH'($signed(imm)) : WIDTH'(imm);
    assign w_opb     = use_imm ? w_imm_ext : b;
    assign w_amt     = (w_opb >= AMT_MAX) ? CNT_MAX : w_opb[CW-1:0];

    assign w_accept     = in_valid && in_ready;
    assign w_start_iter = w_accept && ((is_shift(w_op) && (w_amt != '0)) || (w_op == OP_MUL));
    assign w_iter_cnt   = (w_op == OP_MUL) ? CNT_MAX : w_amt;

    assign w_cin  = (w_op == OP_ADDC) ? r_flags[FLAG_C] : 1'b0;
    assign w_sum  = {1'b0, a} + {1'b0, w_opb} + {{WIDTH{1'b0}}, w_cin};
    assign w_diff = a - w_opb;

    always_comb begin
        w_sc_res   = '0;
        w_sc_flags = '0;
        w_sc_wr    = 1'b1;
        case (w_op)
            OP_ADD, OP_ADDC: begin
                w_sc_res           = w_sum[WIDTH-1:0];
                w_sc_flags[FLAG_C] = w_sum[WIDTH];
                w_sc_flags[FLAG_F] = (a[WIDTH-1] == w_opb[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ADDU: begin
                w_sc_res           = w_sum[WIDTH-1:0];
                w_sc_flags[FLAG_C] = w_sum[WIDTH];
                w_sc_flags[FLAG_F] = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_sc_res           = w_diff;
                w_sc_flags[FLAG_C] = (a < w_opb);
                w_sc_flags[FLAG_F] = (a[WIDTH-1] != w_opb[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_CMP: begin
                w_sc_flags[FLAG_Z] = (a == w_opb);
                w_sc_flags[FLAG_N] = ($signed(a) < $signed(w_opb));
                w_sc_flags[FLAG_L] = (a < w_opb);
            end
            OP_AND:                    w_sc_res = a & w_opb;
            OP_OR:                     w_sc_res = a | w_opb;
            OP_XOR:                    w_sc_res = a ^ w_opb;
            OP_NOT:                    w_sc_res = ~a;
            OP_LSH, OP_RSH, OP_ARSH:   w_sc_res = a;
            default:                   w_sc_wr  = 1'b0;
        endcase
        if (w_op != OP_CMP) begin
            w_sc_flags[FLAG_Z] = (w_sc_res == '0);
            w_sc_flags[FLAG_N] = w_sc_res[WIDTH-1];
        end
    end

    always_comb begin
        w_iter_flags         = '0;
        w_iter_flags[FLAG_Z] = (w_iter_res == '0);
        w_iter_flags[FLAG_N] = w_iter_res[WIDTH-1];
    end

    seq_alu_iter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_iter (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_start_iter),
        .i_op     (w_op),
        .i_a      (a),
        .i_b      (w_opb),
        .i_count  (w_iter_cnt),
        .o_done   (w_iter_done),
        .o_result (w_iter_res)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_iter) w_next = (w_op == OP_MUL) ? ST_MUL : ST_SHIFT;
            ST_SHIFT: if (w_iter_done)  w_next = ST_IDLE;
            ST_MUL:   if (w_iter_done)  w_next = ST_IDLE;
            default:                    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result    <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_accept && !w_start_iter) begin
                r_out_valid <= 1'b1;
                if (w_sc_wr) begin
                    r_result <= w_sc_res;
                    r_flags  <= w_sc_flags;
                end
            end else if ((r_state != ST_IDLE) && w_iter_done) begin
                r_out_valid <= 1'b1;
                r_result    <= w_iter_res;
                r_flags     <= w_iter_flags;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;

endmodule
